fm_ram_arbiter: RTL and testbench

- Shares the single-port feature-map block RAM (word-addressed, 32-bit, byte-write, 1-cycle registered read) between two requesters: M0 = AHB-lite FM data bridge, M1 = accelerator load/store engine.
- Round-robin arbitration, with an optional lock so one requester can stream a bounded burst of back-to-back beats.
- Each accepted read returns its data one cycle later, tagged to its requester.
- Sits between the bus/accelerator front-ends and the FM RAM macro.

---
 rtl/fm_arb_pkg.sv | 26 ++
 rtl/fm_rr_pick.sv | 54 +++++
 rtl/fm_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_fm_ram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_arb_pkg.sv
// Shared types and constants for the feature-map RAM arbiter.
package fm_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    localparam int FM_DATA_W   = 32;
    localparam int FM_BE_W     = 4;
    localparam int BURST_CNT_W = 8;

    // Increment the burst counter, holding at the limit so it never wraps.
    function automatic logic [BURST_CNT_W-1:0] burst_sat_inc(
        input logic [BURST_CNT_W-1:0] cnt,
        input logic [BURST_CNT_W-1:0] limit
    );
        if (cnt < limit) begin
            return cnt + BURST_CNT_W'(1);
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/fm_rr_pick.sv
// Combinational 2-way round-robin picker with lock ownership and burst cap.
module fm_rr_pick
    import fm_arb_pkg::*;
(
    input  logic [1:0]  valid,
    input  logic        last_grant,
    input  arb_state_t  state,
    input  logic        burst_limit_hit,
    output logic [1:0]  grant
);

    logic [1:0] grant_s;

    // Choose at most one requester from the current valids and lock state.
    always_comb begin
        grant_s = 2'b00;
        case (state)
            ARB_LOCK0: begin
                // Owner keeps the slot unless it has used its burst and M1 waits.
                if (valid[0] && !(burst_limit_hit && valid[1])) begin
                    grant_s = 2'b01;
                end else if (valid[1]) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b00;
                end
            end
            ARB_LOCK1: begin
                if (valid[1] && !(burst_limit_hit && valid[0])) begin
                    grant_s = 2'b10;
                end else if (valid[0]) begin
                    grant_s = 2'b01;
                end else begin
                    grant_s = 2'b00;
                end
            end
            default: begin
                // Tie goes to whoever was not served last.
                if (valid == 2'b11) begin
                    grant_s = last_grant ? 2'b01 : 2'b10;
                end else if (valid[0]) begin
                    grant_s = 2'b01;
                end else if (valid[1]) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b00;
                end
            end
        endcase
    end

    assign grant = grant_s;

endmodule

// File: rtl/fm_ram_arbiter.sv
// Shares the single-port FM RAM between the AHB bridge (M0) and the
// accelerator load/store engine (M1). Accepted beats drive the RAM in the
// same cycle; read data returns one cycle later tagged to its requester.
module fm_ram_arbiter
    import fm_arb_pkg::*;
#(
    parameter int FM_ADDR_WIDTH = 13,
    parameter int MAX_BURST     = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESET,

    input  logic                     M0_VALID,
    output logic                     M0_READY,
    input  logic                     M0_WRITE,
    input  logic [FM_ADDR_WIDTH-1:0] M0_ADDR,
    input  logic [FM_DATA_W-1:0]     M0_WDATA,
    input  logic [FM_BE_W-1:0]       M0_BE,
    input  logic                     M0_LOCK,
    output logic                     M0_RVALID,

    input  logic                     M1_VALID,
    output logic                     M1_READY,
    input  logic                     M1_WRITE,
    input  logic [FM_ADDR_WIDTH-1:0] M1_ADDR,
    input  logic [FM_DATA_W-1:0]     M1_WDATA,
    input  logic [FM_BE_W-1:0]       M1_BE,
    input  logic                     M1_LOCK,
    output logic                     M1_RVALID,

    output logic [FM_DATA_W-1:0]     RDATA,

    output logic                     RAM_EN,
    output logic [FM_ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [FM_DATA_W-1:0]     RAM_WDATA,
    output logic [FM_BE_W-1:0]       RAM_WE,
    input  logic [FM_DATA_W-1:0]     RAM_RDATA
);

    localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = BURST_CNT_W'(MAX_BURST);

    arb_state_t               state_r, state_nxt_s;
    logic                     last_grant_r;
    logic [BURST_CNT_W-1:0]   burst_cnt_r, burst_cnt_nxt_s;
    logic                     rd_pend_r;
    logic                     rd_tag_r;
    logic [FM_ADDR_WIDTH-1:0] addr_hold_r;
    logic [FM_DATA_W-1:0]     wdata_hold_r;

    logic [1:0]               pick_grant_s;
    logic [1:0]               grant_s;
    logic                     accept_s;
    logic                     gnt_id_s;
    logic                     same_owner_s;
    logic                     limit_hit_s;

    logic                     sel_write_s;
    logic                     sel_lock_s;
    logic [FM_ADDR_WIDTH-1:0] sel_addr_s;
    logic [FM_DATA_W-1:0]     sel_wdata_s;
    logic [FM_BE_W-1:0]       sel_be_s;

    assign limit_hit_s = (burst_cnt_r >= MAX_BURST_C);

    fm_rr_pick u_pick (
        .valid           ({M1_VALID, M0_VALID}),
        .last_grant      (last_grant_r),
        .state           (state_r),
        .burst_limit_hit (limit_hit_s),
        .grant           (pick_grant_s)
    );

    // Nothing is granted while reset is held, even if requesters are valid.
    assign grant_s  = HRESET ? 2'b00 : pick_grant_s;
    assign accept_s = grant_s[0] | grant_s[1];
    assign gnt_id_s = grant_s[1];
    assign M0_READY = grant_s[0];
    assign M1_READY = grant_s[1];

    assign sel_write_s = gnt_id_s ? M1_WRITE : M0_WRITE;
    assign sel_lock_s  = gnt_id_s ? M1_LOCK  : M0_LOCK;
    assign sel_addr_s  = gnt_id_s ? M1_ADDR  : M0_ADDR;
    assign sel_wdata_s = gnt_id_s ? M1_WDATA : M0_WDATA;
    assign sel_be_s    = gnt_id_s ? M1_BE    : M0_BE;

    // RAM is driven straight from the granted beat; address/data hold otherwise.
    assign RAM_EN    = accept_s;
    assign RAM_ADDR  = accept_s ? sel_addr_s  : addr_hold_r;
    assign RAM_WDATA = accept_s ? sel_wdata_s : wdata_hold_r;
    assign RAM_WE    = (accept_s && sel_write_s) ? sel_be_s : 4'b0000;

    assign M0_RVALID = rd_pend_r & ~rd_tag_r;
    assign M1_RVALID = rd_pend_r &  rd_tag_r;
    assign RDATA     = RAM_RDATA;

    assign same_owner_s = ((state_r == ARB_LOCK0) && !gnt_id_s) ||
                          ((state_r == ARB_LOCK1) &&  gnt_id_s);

    // Next lock state and burst count from the accepted beat or an idle owner.
    always_comb begin
        state_nxt_s     = state_r;
        burst_cnt_nxt_s = burst_cnt_r;
        if (accept_s) begin
            if (sel_lock_s) begin
                state_nxt_s     = gnt_id_s ? ARB_LOCK1 : ARB_LOCK0;
                burst_cnt_nxt_s = same_owner_s ? burst_sat_inc(burst_cnt_r, MAX_BURST_C)
                                               : BURST_CNT_W'(1);
            end else begin
                state_nxt_s     = ARB_IDLE;
                burst_cnt_nxt_s = '0;
            end
        end else if (((state_r == ARB_LOCK0) && !M0_VALID) ||
                     ((state_r == ARB_LOCK1) && !M1_VALID)) begin
            // Owner went quiet with nobody else waiting: release the lock.
            state_nxt_s     = ARB_IDLE;
            burst_cnt_nxt_s = '0;
        end else begin
            state_nxt_s     = state_r;
            burst_cnt_nxt_s = burst_cnt_r;
        end
    end

    // Arbitration state, read-response tag and RAM address/data hold registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r      <= ARB_IDLE;
            last_grant_r <= 1'b1;
            burst_cnt_r  <= '0;
            rd_pend_r    <= 1'b0;
            rd_tag_r     <= 1'b0;
            addr_hold_r  <= '0;
            wdata_hold_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            rd_pend_r   <= accept_s & ~sel_write_s;
            if (accept_s) begin
                last_grant_r <= gnt_id_s;
                rd_tag_r     <= gnt_id_s;
                addr_hold_r  <= sel_addr_s;
                wdata_hold_r <= sel_wdata_s;
            end else begin
                last_grant_r <= last_grant_r;
                rd_tag_r     <= rd_tag_r;
                addr_hold_r  <= addr_hold_r;
                wdata_hold_r <= wdata_hold_r;
            end
        end
    end

endmodule

// File: tb/tb_fm_ram_arbiter.sv
// Directed bench for fm_ram_arbiter with a behavioural 1-cycle FM RAM.
module tb_fm_ram_arbiter;

    localparam int AW = 13;

    logic          HCLK;
    logic          HRESET;
    logic          M0_VALID, M0_READY, M0_WRITE, M0_LOCK, M0_RVALID;
    logic [AW-1:0] M0_ADDR;
    logic [31:0]   M0_WDATA;
    logic [3:0]    M0_BE;
    logic          M1_VALID, M1_READY, M1_WRITE, M1_LOCK, M1_RVALID;
    logic [AW-1:0] M1_ADDR;
    logic [31:0]   M1_WDATA;
    logic [3:0]    M1_BE;
    logic [31:0]   RDATA;
    logic          RAM_EN;
    logic [AW-1:0] RAM_ADDR;
    logic [31:0]   RAM_WDATA;
    logic [3:0]    RAM_WE;
    logic [31:0]   RAM_RDATA;

    logic [31:0]   mem [0:8191];

    int errors = 0;
    int checks = 0;

    fm_ram_arbiter #(.FM_ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_VALID(M0_VALID), .M0_READY(M0_READY), .M0_WRITE(M0_WRITE),
        .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA), .M0_BE(M0_BE),
        .M0_LOCK(M0_LOCK), .M0_RVALID(M0_RVALID),
        .M1_VALID(M1_VALID), .M1_READY(M1_READY), .M1_WRITE(M1_WRITE),
        .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA), .M1_BE(M1_BE),
        .M1_LOCK(M1_LOCK), .M1_RVALID(M1_RVALID),
        .RDATA(RDATA),
        .RAM_EN(RAM_EN), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_WE(RAM_WE), .RAM_RDATA(RAM_RDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Behavioural single-port RAM: read-first, byte writes, registered read.
    always @(posedge HCLK) begin
        if (RAM_EN) begin
            RAM_RDATA <= mem[RAM_ADDR];
            for (int b = 0; b < 4; b++) begin
                if (RAM_WE[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
            end
        end
    end

    task automatic drive_m0(input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic lk);
        M0_VALID = v; M0_WRITE = w; M0_ADDR = a; M0_WDATA = d; M0_BE = be; M0_LOCK = lk;
    endtask

    task automatic drive_m1(input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic lk);
        M1_VALID = v; M1_WRITE = w; M1_ADDR = a; M1_WDATA = d; M1_BE = be; M1_LOCK = lk;
    endtask

    task automatic set_idle();
        M0_VALID = 1'b0; M0_LOCK = 1'b0;
        M1_VALID = 1'b0; M1_LOCK = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        set_idle();
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        drive_m0(1'b1, 1'b0, 13'h003, 32'h0, 4'h0, 1'b0);
        drive_m1(1'b1, 1'b0, 13'h004, 32'h0, 4'h0, 1'b0);
        @(negedge HCLK); #1;
        checks++;
        if ({M0_READY, M1_READY, RAM_EN, RAM_WE, M0_RVALID, M1_RVALID} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b",
                     {M0_READY, M1_READY, RAM_EN, RAM_WE, M0_RVALID, M1_RVALID}, 9'b0);
        end
        checks++;
        if (RAM_ADDR !== 13'h0000) begin
            errors++;
            $display("FAIL reset_ram_addr: got %h want %h", RAM_ADDR, 13'h0000);
        end
        set_idle();
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge HCLK);
        drive_m0(1'b1, 1'b0, 13'h005, 32'h0, 4'h0, 1'b0);
        #1;
        checks++;
        if ({M1_READY, M0_READY, RAM_EN, RAM_WE} !== 7'b0110000 || RAM_ADDR !== 13'h005) begin
            errors++;
            $display("FAIL single_read_issue: got rdy=%b en=%b we=%b addr=%h want rdy=01 en=1 we=0 addr=005",
                     {M1_READY, M0_READY}, RAM_EN, RAM_WE, RAM_ADDR);
        end
        @(negedge HCLK);
        set_idle();
        #1;
        checks++;
        if ({M1_RVALID, M0_RVALID} !== 2'b01 || RDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_read_return: got rv=%b rdata=%h want rv=01 rdata=deadbeef",
                     {M1_RVALID, M0_RVALID}, RDATA);
        end
        checks++;
        if (RAM_EN !== 1'b0 || RAM_ADDR !== 13'h005) begin
            errors++;
            $display("FAIL single_read_hold: got en=%b addr=%h want en=0 addr=005", RAM_EN, RAM_ADDR);
        end
    endtask

    task automatic test_alternation();
        int a0 = 0;
        int a1 = 0;
        logic [1:0]  prev_rv = 2'b00;
        logic [31:0] prev_data = 32'h0;
        logic [AW-1:0] exp_addr;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            drive_m0(1'b1, 1'b0, 13'(16 + a0), 32'h0, 4'h0, 1'b0);
            drive_m1(1'b1, 1'b0, 13'(32 + a1), 32'h0, 4'h0, 1'b0);
            #1;
            exp_addr = (i % 2 == 0) ? 13'(16 + a0) : 13'(32 + a1);
            checks++;
            if ({M1_READY, M0_READY} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || RAM_ADDR !== exp_addr) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got rdy=%b addr=%h want rdy=%b addr=%h", i,
                         {M1_READY, M0_READY}, RAM_ADDR, (i % 2 == 0) ? 2'b01 : 2'b10, exp_addr);
            end
            if (i > 0) begin
                checks++;
                if ({M1_RVALID, M0_RVALID} !== prev_rv || RDATA !== prev_data) begin
                    errors++;
                    $display("FAIL alt_return[%0d]: got rv=%b rdata=%h want rv=%b rdata=%h", i,
                             {M1_RVALID, M0_RVALID}, RDATA, prev_rv, prev_data);
                end
            end
            prev_rv   = (i % 2 == 0) ? 2'b01 : 2'b10;
            prev_data = 32'hA500_0000 + 32'(exp_addr);
            if (i % 2 == 0) a0++; else a1++;
        end
        @(negedge HCLK);
        set_idle();
        #1;
        checks++;
        if ({M1_RVALID, M0_RVALID} !== 2'b10 || RDATA !== 32'hA500_0022) begin
            errors++;
            $display("FAIL alt_last_return: got rv=%b rdata=%h want rv=10 rdata=a5000022",
                     {M1_RVALID, M0_RVALID}, RDATA);
        end
    endtask

    task automatic test_lock_burst();
        logic [3:0] be_tab [4] = '{4'b1111, 4'b0011, 4'b1100, 4'b0101};
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            drive_m1(1'b1, 1'b1, 13'(256 + k), 32'hB000_0000 + 32'(k), be_tab[k], 1'b1);
            drive_m0((k > 0) ? 1'b1 : 1'b0, 1'b0, 13'h040, 32'h0, 4'h0, 1'b0);
            #1;
            checks++;
            if ({M1_READY, M0_READY} !== 2'b10 || RAM_WE !== be_tab[k] || RAM_ADDR !== 13'(256 + k)) begin
                errors++;
                $display("FAIL lock_beat[%0d]: got rdy=%b we=%b addr=%h want rdy=10 we=%b addr=%h", k,
                         {M1_READY, M0_READY}, RAM_WE, RAM_ADDR, be_tab[k], 13'(256 + k));
            end
        end
        @(negedge HCLK);
        drive_m1(1'b1, 1'b1, 13'h104, 32'hB000_0004, 4'b1111, 1'b1);
        #1;
        checks++;
        if ({M1_READY, M0_READY} !== 2'b01 || RAM_WE !== 4'b0000 || RAM_ADDR !== 13'h040) begin
            errors++;
            $display("FAIL lock_limit_yield: got rdy=%b we=%b addr=%h want rdy=01 we=0000 addr=040",
                     {M1_READY, M0_READY}, RAM_WE, RAM_ADDR);
        end
        @(negedge HCLK);
        M0_VALID = 1'b0;
        #1;
        checks++;
        if ({M1_READY, M0_READY} !== 2'b10 || RAM_ADDR !== 13'h104 || M0_RVALID !== 1'b1 ||
            RDATA !== 32'hA500_0040) begin
            errors++;
            $display("FAIL lock_resume: got rdy=%b addr=%h rv0=%b rdata=%h want rdy=10 addr=104 rv0=1 rdata=a5000040",
                     {M1_READY, M0_READY}, RAM_ADDR, M0_RVALID, RDATA);
        end
        @(negedge HCLK);
        set_idle();
    endtask

    task automatic test_lock_idle();
        @(negedge HCLK);
        drive_m0(1'b1, 1'b0, 13'h050, 32'h0, 4'h0, 1'b1);
        #1;
        checks++;
        if ({M1_READY, M0_READY} !== 2'b01) begin
            errors++;
            $display("FAIL lockidle_c0: got rdy=%b want 01", {M1_READY, M0_READY});
        end
        @(negedge HCLK);
        drive_m0(1'b1, 1'b0, 13'h051, 32'h0, 4'h0, 1'b1);
        drive_m1(1'b1, 1'b0, 13'h060, 32'h0, 4'h0, 1'b0);
        #1;
        checks++;
        if ({M1_READY, M0_READY} !== 2'b01 || M0_RVALID !== 1'b1 || RDATA !== 32'hA500_0050) begin
            errors++;
            $display("FAIL lockidle_c1: got rdy=%b rv0=%b rdata=%h want rdy=01 rv0=1 rdata=a5000050",
                     {M1_READY, M0_READY}, M0_RVALID, RDATA);
        end
        @(negedge HCLK);
        M0_VALID = 1'b0;
        #1;
        checks++;
        if ({M1_READY, M0_READY} !== 2'b10 || RAM_ADDR !== 13'h060 || RDATA !== 32'hA500_0051) begin
            errors++;
            $display("FAIL lockidle_handover: got rdy=%b addr=%h rdata=%h want rdy=10 addr=060 rdata=a5000051",
                     {M1_READY, M0_READY}, RAM_ADDR, RDATA);
        end
        @(negedge HCLK);
        drive_m0(1'b1, 1'b0, 13'h052, 32'h0, 4'h0, 1'b0);
        drive_m1(1'b1, 1'b0, 13'h061, 32'h0, 4'h0, 1'b0);
        #1;
        checks++;
        if ({M1_READY, M0_READY} !== 2'b01 || M1_RVALID !== 1'b1 || RDATA !== 32'hA500_0060) begin
            errors++;
            $display("FAIL lockidle_back_to_idle: got rdy=%b rv1=%b rdata=%h want rdy=01 rv1=1 rdata=a5000060",
                     {M1_READY, M0_READY}, M1_RVALID, RDATA);
        end
        @(negedge HCLK);
        set_idle();
        #1;
        checks++;
        if ({M1_RVALID, M0_RVALID} !== 2'b01 || RDATA !== 32'hA500_0052) begin
            errors++;
            $display("FAIL lockidle_last_return: got rv=%b rdata=%h want rv=01 rdata=a5000052",
                     {M1_RVALID, M0_RVALID}, RDATA);
        end
    endtask

    task automatic test_byte_write();
        @(negedge HCLK);
        drive_m1(1'b1, 1'b1, 13'h1FFF, 32'h1122_3344, 4'b0110, 1'b0);
        #1;
        checks++;
        if (M1_READY !== 1'b1 || RAM_WE !== 4'b0110 || RAM_ADDR !== 13'h1FFF || RAM_WDATA !== 32'h1122_3344) begin
            errors++;
            $display("FAIL byte_write_issue: got rdy=%b we=%b addr=%h wdata=%h want rdy=1 we=0110 addr=1fff wdata=11223344",
                     M1_READY, RAM_WE, RAM_ADDR, RAM_WDATA);
        end
        @(negedge HCLK);
        drive_m1(1'b1, 1'b0, 13'h1FFF, 32'h0, 4'h0, 1'b0);
        #1;
        checks++;
        if (M1_READY !== 1'b1 || RAM_WE !== 4'b0000 || M1_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL byte_readback_issue: got rdy=%b we=%b rv1=%b want rdy=1 we=0000 rv1=0",
                     M1_READY, RAM_WE, M1_RVALID);
        end
        @(negedge HCLK);
        M1_VALID = 1'b0;
        drive_m0(1'b1, 1'b1, 13'h070, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        #1;
        checks++;
        if (M1_RVALID !== 1'b1 || RDATA !== 32'hAA22_33DD) begin
            errors++;
            $display("FAIL byte_merge: got rv1=%b rdata=%h want rv1=1 rdata=aa2233dd", M1_RVALID, RDATA);
        end
        checks++;
        if (M0_READY !== 1'b1 || RAM_EN !== 1'b1 || RAM_WE !== 4'b0000) begin
            errors++;
            $display("FAIL zero_be_write: got rdy=%b en=%b we=%b want rdy=1 en=1 we=0000", M0_READY, RAM_EN, RAM_WE);
        end
        @(negedge HCLK);
        set_idle();
        #1;
        checks++;
        if ({M1_RVALID, M0_RVALID} !== 2'b00 || RAM_EN !== 1'b0 || RAM_ADDR !== 13'h070) begin
            errors++;
            $display("FAIL write_no_response: got rv=%b en=%b addr=%h want rv=00 en=0 addr=070",
                     {M1_RVALID, M0_RVALID}, RAM_EN, RAM_ADDR);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge HCLK);
        drive_m0(1'b1, 1'b0, 13'h005, 32'h0, 4'h0, 1'b0);
        #1;
        checks++;
        if (M0_READY !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got rdy0=%b want 1", M0_READY);
        end
        #1;
        HRESET = 1'b1;
        #1;
        checks++;
        if ({M0_READY, M1_READY, RAM_EN, RAM_WE} !== 7'b0 || RAM_ADDR !== 13'h0000) begin
            errors++;
            $display("FAIL midrst_outputs: got rdy=%b en=%b we=%b addr=%h want all 0",
                     {M1_READY, M0_READY}, RAM_EN, RAM_WE, RAM_ADDR);
        end
        @(negedge HCLK);
        #1;
        checks++;
        if ({M1_RVALID, M0_RVALID} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_no_rvalid: got rv=%b want 00", {M1_RVALID, M0_RVALID});
        end
        HRESET = 1'b0;
        drive_m0(1'b1, 1'b0, 13'h080, 32'h0, 4'h0, 1'b0);
        drive_m1(1'b1, 1'b0, 13'h090, 32'h0, 4'h0, 1'b0);
        #1;
        checks++;
        if ({M1_READY, M0_READY} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_first_tie: got rdy=%b want 01", {M1_READY, M0_READY});
        end
        @(negedge HCLK);
        set_idle();
        #1;
        checks++;
        if ({M1_RVALID, M0_RVALID} !== 2'b01 || RDATA !== 32'hA500_0080) begin
            errors++;
            $display("FAIL midrst_after_release: got rv=%b rdata=%h want rv=01 rdata=a5000080",
                     {M1_RVALID, M0_RVALID}, RDATA);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] <= 32'hA500_0000 + 32'(i);
        mem[5]       <= 32'hDEAD_BEEF;
        mem[13'h1FFF] <= 32'hAABB_CCDD;
        HRESET = 1'b1;
        drive_m0(1'b0, 1'b0, 13'h000, 32'h0, 4'h0, 1'b0);
        drive_m1(1'b0, 1'b0, 13'h000, 32'h0, 4'h0, 1'b0);
        test_reset();
        test_single_read();
        test_alternation();
        test_lock_burst();
        test_lock_idle();
        test_byte_write();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
